mul_sequencer: RTL and testbench
================================

# mul_sequencer

Issue-side sequencer for the RV32M multiply instructions, placed between the execute-stage dispatch and the `fractionned_multiplier` core. It accepts one MUL/MULH/MULHSU/MULHU request at a time and converts signed operands to magnitudes. It drives the core's enable and waits for its valid. It then applies the sign fix-up to the 64-bit product and returns the selected 32-bit word over a valid/ready response port.

## Interface
Parameters:
- `TIMEOUT`, 64: maximum cycles spent in WAIT before the request aborts with an error.
- `TAG_W`, 5: width of the destination tag carried from request to response.

Ports:
- `clock`  in  1  single clock, rising edge.
- `reset_n`  in  1  asynchronous active-low reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  request accepted on `req_valid & req_ready`.
- `req_op`  in  2  00 MUL, 01 MULH, 10 MULHSU, 11 MULHU.
- `req_rs1`, `req_rs2`  in  32  operands.
- `req_tag`  in  TAG_W  destination tag.
- `mul_a`, `mul_b`  out  32  operand magnitudes to the core.
- `mul_enable`  out  1  core run enable.
- `mul_lower`, `mul_higher`  in  32  unsigned product from the core.
- `mul_valid`  in  1  core result valid.
- `rsp_valid`  out  1  response present.
- `rsp_ready`  in  1  consumer accepts the response.
- `rsp_data`  out  32  result word.
- `rsp_tag`  out  TAG_W  tag of the request.
- `rsp_error`  out  1  timeout abort; `rsp_data` is 0 when set.

## Operation
- States: IDLE, WAIT, FIXUP, RESP.
- `req_ready` = (state==IDLE) & ~`mul_valid`. This guarantees the core has cleared its index and valid before the next launch.
- On accept:
  - latch op, tag, `req_rs1` and `req_rs2`.
  - sa = op∈{MULH,MULHSU}; sb = op==MULH.
  - `mul_a` = sa&rs1[31] ? -rs1 : rs1; `mul_b` = sb&rs2[31] ? -rs2 : rs2. Both are 32-bit unsigned; -0x80000000 gives 0x80000000.
  - neg = (sa&rs1[31]) ^ (sb&rs2[31]).
  - Go to WAIT.
- WAIT:
  - `mul_enable`=1; the timeout counter increments each cycle.
  - `mul_valid`=1 → capture {`mul_higher`,`mul_lower`}, go to FIXUP.
  - Counter reaches TIMEOUT → `rsp_error`=1, `rsp_data`=0, go to RESP.
- FIXUP: P = neg ? -{hi,lo} (64-bit two's complement) : {hi,lo}; `rsp_data` = op==MUL ? P[31:0] : P[63:32]; go to RESP.
- RESP: `rsp_valid`=1; data, tag and error are held stable until `rsp_ready`=1, then go to IDLE.
- `mul_enable`=0 in every state other than WAIT.
- Reset, asynchronous, from any state:
  - state IDLE; counter 0; cache invalid.
  - `mul_enable`, `rsp_valid`, `rsp_error` = 0.
  - `mul_a`, `mul_b`, `rsp_data`, `rsp_tag` = 0.
  - Because enable drops, the core clears itself; a reset in the middle of an operation produces no response.

## Timing
- Accept at edge N → `mul_enable` high from N+1.
- The core needs 33 enabled cycles, so `mul_valid` is sampled high at edge N+34.
- FIXUP takes one cycle, so `rsp_valid` rises after edge N+35.
- Minimum uncached latency, accept to response: 35 cycles.
- Throughput: one request per (latency + 1 + cycles `mul_valid` stays high after enable drops).
- `rsp_valid` and `rsp_ready` high on the same edge completes the response; `req_ready` can rise on the next cycle at the earliest.
- Timeout: WAIT exits after exactly TIMEOUT cycles if `mul_valid` never rises.

## Configuration
- `MUL_RESULT_CACHE_EN` defined:
  - Stores rs1, rs2, {sa,sb}, the fixed-up 64-bit P and a valid bit, written in FIXUP.
  - A request hits when rs1 and rs2 match and either (op==MUL) or {sa,sb} match.
  - On a hit, IDLE goes directly to RESP: response one cycle after accept, `mul_enable` never asserted.
  - The cache is invalidated on reset and on timeout.
- `MUL_RESULT_CACHE_EN` undefined: no cache storage; every request goes through WAIT.

## Test plan
- MUL 7×6, tag 3 → `rsp_data`=0x0000002A, `rsp_tag`=3, `rsp_error`=0; `rsp_valid` 35 cycles after accept.
- MULH 0xFFFFFFFF×0x00000002 → 0xFFFFFFFF; MULHU with the same operands → 0x00000001.
- MULHSU 0x80000000×0xFFFFFFFF → 0x80000000 (P=0x8000000080000000); MULH 0x80000000×0x80000000 → 0x40000000.
- Hold `rsp_ready` low 10 cycles in RESP → `rsp_valid`, data and tag stable; `req_ready`=0 throughout; a single accept when `rsp_ready` goes high.
- TIMEOUT=40 with `mul_valid` tied low → `rsp_error`=1 and `rsp_data`=0 after 40 WAIT cycles; `reset_n` pulsed during WAIT → `mul_enable`=0 and `rsp_valid`=0 immediately, no response issued.
- With `MUL_RESULT_CACHE_EN`: MULH 5×9 followed by MUL 5×9 → second response (0x0000002D) one cycle after accept, with no `mul_enable` pulse. Without the macro → normal 35-cycle latency.

Source files
------------

// File: rtl/mul_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : mul_sequencer
//  Description : Issue-side sequencer for RV32M MUL/MULH/MULHSU/MULHU.
//                Takes one request at a time and turns signed operands into
//                magnitudes for an unsigned multiplier core. It runs the core
//                until its result is valid, or until TIMEOUT cycles pass. It
//                then applies the sign fix-up and returns the selected
//                32-bit word on a valid/ready response port.
//  Optional    : `define MUL_RESULT_CACHE_EN adds a one-entry result cache
//                that answers a repeated request without running the core.
//  Ports       :
//    clock, reset_n                 clock / asynchronous active-low reset
//    req_valid/ready/op/rs1/rs2/tag request channel (op 00 MUL, 01 MULH,
//                                   10 MULHSU, 11 MULHU)
//    mul_a, mul_b, mul_enable       operand magnitudes and run enable to core
//    mul_lower, mul_higher, mul_valid  unsigned 64-bit product from core
//    rsp_valid/ready/data/tag/error response channel (error = timeout abort)
//  Revision    : 1.0  initial release
// ============================================================================
module mul_sequencer #(
  parameter int TIMEOUT = 64,
  parameter int TAG_W   = 5
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [1:0]       req_op,
  input  logic [31:0]      req_rs1,
  input  logic [31:0]      req_rs2,
  input  logic [TAG_W-1:0] req_tag,
  output logic [31:0]      mul_a,
  output logic [31:0]      mul_b,
  output logic             mul_enable,
  input  logic [31:0]      mul_lower,
  input  logic [31:0]      mul_higher,
  input  logic             mul_valid,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [31:0]      rsp_data,
  output logic [TAG_W-1:0] rsp_tag,
  output logic             rsp_error
);

  localparam logic [1:0]       OP_MUL    = 2'b00;
  localparam logic [1:0]       OP_MULH   = 2'b01;
  localparam logic [1:0]       OP_MULHSU = 2'b10;
  localparam int               CNT_W     = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WAIT  = 2'd1,
    S_FIXUP = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       op_q, op_d;
  logic             neg_q, neg_d;
  logic [63:0]      prod_q, prod_d;
  logic [31:0]      mul_a_q, mul_a_d;
  logic [31:0]      mul_b_q, mul_b_d;
  logic [31:0]      rsp_data_q, rsp_data_d;
  logic [TAG_W-1:0] rsp_tag_q, rsp_tag_d;
  logic             rsp_error_q, rsp_error_d;

  logic        w_accept;
  logic        w_sa, w_sb, w_neg_a, w_neg_b;
  logic [31:0] w_mag_a, w_mag_b;
  logic [63:0] w_prod_fix;
  logic [31:0] w_word;
  logic        w_hit;
  logic [31:0] w_hit_word;

  // Holding off while mul_valid is still high lets the core clear its
  // internal index and valid before it is enabled again.
  assign req_ready  = (state_q == S_IDLE) & ~mul_valid;
  assign w_accept   = req_valid & req_ready;
  assign mul_enable = (state_q == S_WAIT);
  assign rsp_valid  = (state_q == S_RESP);

  assign mul_a      = mul_a_q;
  assign mul_b      = mul_b_q;
  assign rsp_data   = rsp_data_q;
  assign rsp_tag    = rsp_tag_q;
  assign rsp_error  = rsp_error_q;

  // Operand sign handling; negating 0x80000000 wraps back to 0x80000000,
  // which is exactly its magnitude as an unsigned 32-bit number.
  assign w_sa    = (req_op == OP_MULH) | (req_op == OP_MULHSU);
  assign w_sb    = (req_op == OP_MULH);
  assign w_neg_a = w_sa & req_rs1[31];
  assign w_neg_b = w_sb & req_rs2[31];
  assign w_mag_a = w_neg_a ? (~req_rs1 + 32'd1) : req_rs1;
  assign w_mag_b = w_neg_b ? (~req_rs2 + 32'd1) : req_rs2;

  assign w_prod_fix = neg_q ? (~prod_q + 64'd1) : prod_q;
  assign w_word     = (op_q == OP_MUL) ? w_prod_fix[31:0] : w_prod_fix[63:32];

`ifdef MUL_RESULT_CACHE_EN
  logic [31:0] rs1_q, rs2_q;
  logic [1:0]  sasb_q;
  logic [31:0] cache_rs1_q, cache_rs2_q;
  logic [1:0]  cache_sasb_q;
  logic [63:0] cache_prod_q;
  logic        cache_valid_q;
  logic        w_timeout;

  assign w_timeout = (state_q == S_WAIT) & ~mul_valid & (cnt_q == CNT_LAST);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rs1_q         <= '0;
      rs2_q         <= '0;
      sasb_q        <= '0;
      cache_rs1_q   <= '0;
      cache_rs2_q   <= '0;
      cache_sasb_q  <= '0;
      cache_prod_q  <= '0;
      cache_valid_q <= 1'b0;
    end else begin
      if (w_accept) begin
        rs1_q  <= req_rs1;
        rs2_q  <= req_rs2;
        sasb_q <= {w_sa, w_sb};
      end
      if (state_q == S_FIXUP) begin
        cache_rs1_q   <= rs1_q;
        cache_rs2_q   <= rs2_q;
        cache_sasb_q  <= sasb_q;
        cache_prod_q  <= w_prod_fix;
        cache_valid_q <= 1'b1;
      end else if (w_timeout) begin
        cache_valid_q <= 1'b0;
      end
    end
  end

  // The low word of the product does not depend on operand signedness,
  // so MUL hits regardless of which signedness filled the entry.
  assign w_hit = cache_valid_q & (req_rs1 == cache_rs1_q) & (req_rs2 == cache_rs2_q)
               & ((req_op == OP_MUL) | ({w_sa, w_sb} == cache_sasb_q));
  assign w_hit_word = (req_op == OP_MUL) ? cache_prod_q[31:0] : cache_prod_q[63:32];
`else
  assign w_hit      = 1'b0;
  assign w_hit_word = 32'd0;
`endif

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    op_d        = op_q;
    neg_d       = neg_q;
    prod_d      = prod_q;
    mul_a_d     = mul_a_q;
    mul_b_d     = mul_b_q;
    rsp_data_d  = rsp_data_q;
    rsp_tag_d   = rsp_tag_q;
    rsp_error_d = rsp_error_q;
    case (state_q)
      S_IDLE: begin
        if (w_accept) begin
          op_d        = req_op;
          rsp_tag_d   = req_tag;
          mul_a_d     = w_mag_a;
          mul_b_d     = w_mag_b;
          neg_d       = w_neg_a ^ w_neg_b;
          cnt_d       = '0;
          rsp_error_d = 1'b0;
          if (w_hit) begin
            rsp_data_d = w_hit_word;
            state_d    = S_RESP;
          end else begin
            state_d    = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (mul_valid) begin
          prod_d  = {mul_higher, mul_lower};
          state_d = S_FIXUP;
        end else if (cnt_q == CNT_LAST) begin
          rsp_error_d = 1'b1;
          rsp_data_d  = '0;
          state_d     = S_RESP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_FIXUP: begin
        rsp_data_d = w_word;
        state_d    = S_RESP;
      end
      S_RESP: begin
        if (rsp_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      op_q        <= '0;
      neg_q       <= 1'b0;
      prod_q      <= '0;
      mul_a_q     <= '0;
      mul_b_q     <= '0;
      rsp_data_q  <= '0;
      rsp_tag_q   <= '0;
      rsp_error_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      op_q        <= op_d;
      neg_q       <= neg_d;
      prod_q      <= prod_d;
      mul_a_q     <= mul_a_d;
      mul_b_q     <= mul_b_d;
      rsp_data_q  <= rsp_data_d;
      rsp_tag_q   <= rsp_tag_d;
      rsp_error_q <= rsp_error_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mul_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mul_sequencer
//  Description : Self-checking bench for mul_sequencer. A behavioural model
//                of the multiplier core answers after 33 enabled cycles.
//                Expected responses are pushed to a scoreboard when a request
//                is issued and popped when the response appears.
//                Latency is the edge offset from the accept edge to the edge
//                after which rsp_valid is high.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_mul_sequencer;

  localparam int TAG_W    = 5;
  localparam int TIMEOUT  = 40;
  localparam int LAT_MISS = 35;
  localparam int LAT_HIT  = 0;   // RESP entered on the accept edge itself
`ifdef MUL_RESULT_CACHE_EN
  localparam int EN_SECOND = 0;
`else
  localparam int EN_SECOND = 34;
`endif

  logic             clock = 1'b0;
  logic             reset_n = 1'b0;
  logic             req_valid = 1'b0;
  logic             req_ready;
  logic [1:0]       req_op = '0;
  logic [31:0]      req_rs1 = '0;
  logic [31:0]      req_rs2 = '0;
  logic [TAG_W-1:0] req_tag = '0;
  logic [31:0]      mul_a, mul_b;
  logic             mul_enable;
  logic [31:0]      mul_lower = '0;
  logic [31:0]      mul_higher = '0;
  logic             mul_valid = 1'b0;
  logic             rsp_valid;
  logic             rsp_ready = 1'b0;
  logic [31:0]      rsp_data;
  logic [TAG_W-1:0] rsp_tag;
  logic             rsp_error;

  mul_sequencer #(.TIMEOUT(TIMEOUT), .TAG_W(TAG_W)) dut (
    .clock(clock), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_rs1(req_rs1), .req_rs2(req_rs2), .req_tag(req_tag),
    .mul_a(mul_a), .mul_b(mul_b), .mul_enable(mul_enable),
    .mul_lower(mul_lower), .mul_higher(mul_higher), .mul_valid(mul_valid),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_tag(rsp_tag), .rsp_error(rsp_error)
  );

  always #5 clock = ~clock;

  // Core model: after 33 enabled edges it raises valid with the unsigned
  // product and holds it while enabled; dropping enable clears it.
  int mcnt = 0;
  bit stall = 1'b0;
  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      mcnt <= 0; mul_valid <= 1'b0;
    end else if (!mul_enable) begin
      mcnt <= 0; mul_valid <= 1'b0;
    end else begin
      mcnt <= mcnt + 1;
      if (mcnt == 32 && !stall) begin
        mul_valid <= 1'b1;
        {mul_higher, mul_lower} <= {32'd0, mul_a} * {32'd0, mul_b};
      end
    end
  end

  int cyc = 0, en_cnt = 0, acc_cnt = 0;
  always @(posedge clock) begin
    cyc++;
    if (mul_enable) en_cnt++;
    if (req_valid && req_ready) acc_cnt++;
  end

  typedef struct {
    logic [31:0]      data;
    logic [TAG_W-1:0] tag;
    logic             err;
    int               lat;
    int               acc;
  } exp_t;
  exp_t sb[$];

  int total = 0, bad = 0;

  // Bench-side image of the one-entry result cache.
  bit          m_v = 1'b0;
  logic [31:0] m_rs1 = '0, m_rs2 = '0;
  logic [1:0]  m_sasb = '0;

  function automatic logic [31:0] ref_mul(input logic [1:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    logic [63:0] ea, eb, p;
    ea = (op == 2'b01 || op == 2'b10) ? {{32{a[31]}}, a} : {32'd0, a};
    eb = (op == 2'b01) ? {{32{b[31]}}, b} : {32'd0, b};
    p  = ea * eb;
    return (op == 2'b00) ? p[31:0] : p[63:32];
  endfunction

  task automatic send(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                      input logic [TAG_W-1:0] tag, input logic [31:0] exp_data,
                      input bit expect_rsp);
    exp_t e;
    bit hit;
    int g;
    logic [1:0] sasb;
    sasb = {(op == 2'b01) || (op == 2'b10), op == 2'b01};
    hit = 1'b0;
`ifdef MUL_RESULT_CACHE_EN
    hit = m_v && (a == m_rs1) && (b == m_rs2) && (op == 2'b00 || sasb == m_sasb);
`endif
    e.tag = tag;
    if (stall) begin
      e.data = 32'd0; e.err = 1'b1; e.lat = TIMEOUT; m_v = 1'b0;
    end else begin
      e.data = exp_data; e.err = 1'b0; e.lat = hit ? LAT_HIT : LAT_MISS;
      if (!hit) begin m_v = 1'b1; m_rs1 = a; m_rs2 = b; m_sasb = sasb; end
    end
    @(negedge clock);
    req_valid = 1'b1; req_op = op; req_rs1 = a; req_rs2 = b; req_tag = tag;
    g = 0;
    while (!req_ready && g < 200) begin @(negedge clock); g++; end
    total++;
    if (!req_ready) begin
      bad++;
      $display("FAIL accept_wait: req_ready=%b required 1 within 200 cycles", req_ready);
    end else begin
      e.acc = cyc + 1;
      if (expect_rsp) sb.push_back(e);
    end
    @(negedge clock);
    req_valid = 1'b0;
  endtask

  task automatic receive(input int hold);
    exp_t e;
    int g, lat;
    logic [31:0] d0;
    logic [TAG_W-1:0] t0;
    g = 0;
    while (!rsp_valid && g < 300) begin @(negedge clock); g++; end
    total++;
    if (!rsp_valid) begin
      bad++;
      $display("FAIL rsp_wait: rsp_valid=%b required 1 within 300 cycles", rsp_valid);
      return;
    end
    total++;
    if (sb.size() == 0) begin
      bad++;
      $display("FAIL rsp_unexpected: scoreboard empty, got data=%h", rsp_data);
      return;
    end
    e = sb.pop_front();
    lat = cyc - e.acc;
    total++;
    if (rsp_data !== e.data) begin
      bad++; $display("FAIL rsp_data: got %h required %h", rsp_data, e.data);
    end
    total++;
    if (rsp_tag !== e.tag) begin
      bad++; $display("FAIL rsp_tag: got %0d required %0d", rsp_tag, e.tag);
    end
    total++;
    if (rsp_error !== e.err) begin
      bad++; $display("FAIL rsp_error: got %b required %b", rsp_error, e.err);
    end
    total++;
    if (lat != e.lat) begin
      bad++; $display("FAIL latency: got %0d required %0d", lat, e.lat);
    end
    d0 = rsp_data; t0 = rsp_tag;
    for (int i = 0; i < hold; i++) begin
      @(negedge clock);
      total++;
      if (rsp_valid !== 1'b1 || rsp_data !== d0 || rsp_tag !== t0 || req_ready !== 1'b0) begin
        bad++;
        $display("FAIL hold_stable: valid=%b data=%h tag=%0d req_ready=%b required 1 %h %0d 0",
                 rsp_valid, rsp_data, rsp_tag, req_ready, d0, t0);
      end
    end
    rsp_ready = 1'b1;
    @(negedge clock);
    rsp_ready = 1'b0;
    total++;
    if (rsp_valid !== 1'b0) begin
      bad++; $display("FAIL rsp_release: rsp_valid=%b required 0", rsp_valid);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    total++;
    if (req_ready !== 1'b1) begin bad++; $display("FAIL reset_req_ready: got %b required 1", req_ready); end
    total++;
    if (mul_enable !== 1'b0 || rsp_valid !== 1'b0 || rsp_error !== 1'b0) begin
      bad++; $display("FAIL reset_ctrl: en=%b valid=%b err=%b required 0 0 0", mul_enable, rsp_valid, rsp_error);
    end
    total++;
    if (rsp_data !== 32'd0 || rsp_tag !== '0) begin
      bad++; $display("FAIL reset_rsp: data=%h tag=%0d required 0 0", rsp_data, rsp_tag);
    end
    total++;
    if (mul_a !== 32'd0 || mul_b !== 32'd0) begin
      bad++; $display("FAIL reset_operands: a=%h b=%h required 0 0", mul_a, mul_b);
    end
  endtask

  task automatic test_basic();
    send(2'b00, 32'd7, 32'd6, 5'd3, 32'h0000002A, 1'b1);
    receive(0);
  endtask

  task automatic test_signs();
    send(2'b01, 32'hFFFFFFFF, 32'h00000002, 5'd4, 32'hFFFFFFFF, 1'b1); receive(0);
    send(2'b11, 32'hFFFFFFFF, 32'h00000002, 5'd5, 32'h00000001, 1'b1); receive(0);
    send(2'b10, 32'h80000000, 32'hFFFFFFFF, 5'd6, 32'h80000000, 1'b1); receive(0);
    send(2'b01, 32'h80000000, 32'h80000000, 5'd7, 32'h40000000, 1'b1); receive(0);
  endtask

  task automatic test_hold();
    int a0;
    a0 = acc_cnt;
    send(2'b00, 32'h00001234, 32'h00000010, 5'd12, 32'h00012340, 1'b1);
    receive(10);
    total++;
    if (acc_cnt - a0 != 1) begin
      bad++; $display("FAIL hold_accepts: got %0d required 1", acc_cnt - a0);
    end
  endtask

  task automatic test_timeout();
    int e0;
    stall = 1'b1;
    e0 = en_cnt;
    send(2'b00, 32'd3, 32'd4, 5'd9, 32'd12, 1'b1);
    receive(0);
    stall = 1'b0;
    total++;
    if (en_cnt - e0 != TIMEOUT) begin
      bad++; $display("FAIL timeout_enable_cycles: got %0d required %0d", en_cnt - e0, TIMEOUT);
    end
  endtask

  task automatic test_reset_mid();
    bit seen;
    send(2'b01, 32'h00000011, 32'h00000022, 5'd13, 32'd0, 1'b0);
    repeat (10) @(negedge clock);
    #2 reset_n = 1'b0;
    #1;
    total++;
    if (mul_enable !== 1'b0 || rsp_valid !== 1'b0) begin
      bad++; $display("FAIL reset_mid: en=%b valid=%b required 0 0", mul_enable, rsp_valid);
    end
    @(negedge clock);
    reset_n = 1'b1;
    m_v = 1'b0;
    seen = 1'b0;
    repeat (60) begin @(negedge clock); if (rsp_valid) seen = 1'b1; end
    total++;
    if (seen) begin bad++; $display("FAIL reset_mid_no_rsp: rsp_valid seen=%b required 0", seen); end
  endtask

  task automatic test_cache();
    int e0;
    send(2'b01, 32'd5, 32'd9, 5'd1, 32'h00000000, 1'b1); receive(0);
    e0 = en_cnt;
    send(2'b00, 32'd5, 32'd9, 5'd2, 32'h0000002D, 1'b1); receive(0);
    total++;
    if (en_cnt - e0 != EN_SECOND) begin
      bad++; $display("FAIL cache_enable_cycles: got %0d required %0d", en_cnt - e0, EN_SECOND);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] pool [6];
    logic [1:0]  op;
    logic [31:0] a, b;
    pool = '{32'd0, 32'd1, 32'hFFFFFFFF, 32'h80000000, 32'h7FFFFFFF, 32'h12345678};
    for (int i = 0; i < 10; i++) begin
      op = 2'($urandom_range(0, 3));
      a  = pool[$urandom_range(0, 5)];
      b  = pool[$urandom_range(0, 5)];
      send(op, a, b, TAG_W'(i + 16), ref_mul(op, a, b), 1'b1);
      receive(0);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_signs();
    test_hold();
    test_timeout();
    test_reset_mid();
    test_cache();
    test_back_to_back();
    total++;
    if (sb.size() != 0) begin
      bad++; $display("FAIL scoreboard_drain: %0d left required 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
